// File: rtl/afe_seq_ctrl_if.sv
// Host/AFE signal bundle for the AFE frame sequencer.
// The master modport is the host side; the slave modport is the sequencer.
interface afe_seq_ctrl_if #(
  parameter int TW     = 17,
  parameter int NUM_CH = 64
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            start;
  logic            abort;
  logic            cont_mode;
  logic [TW-1:0]   tft_on_cyc;
  logic [TW-1:0]   tft_off_cyc;
  logic [2:0]      pga_sel;
  logic            df_sm_in;

  logic            AFE_IRST;
  logic            AFE_SHR;
  logic            AFE_INTG;
  logic            AFE_SHS;
  logic            AFE_CLK;
  logic            AFE_ENTRI;
  logic            AFE_DF_SM;
  logic [2:0]      AFE_PGA;
  logic            busy;
  logic            done;
  logic            ch_strobe;
  logic [CH_W-1:0] ch_idx;
  logic [15:0]     frame_cnt;

  modport master (
    output start, abort, cont_mode, tft_on_cyc, tft_off_cyc, pga_sel, df_sm_in,
    input  AFE_IRST, AFE_SHR, AFE_INTG, AFE_SHS, AFE_CLK, AFE_ENTRI, AFE_DF_SM, AFE_PGA,
    input  busy, done, ch_strobe, ch_idx, frame_cnt
  );

  modport slave (
    input  start, abort, cont_mode, tft_on_cyc, tft_off_cyc, pga_sel, df_sm_in,
    output AFE_IRST, AFE_SHR, AFE_INTG, AFE_SHS, AFE_CLK, AFE_ENTRI, AFE_DF_SM, AFE_PGA,
    output busy, done, ch_strobe, ch_idx, frame_cnt
  );
endinterface

// File: rtl/afe_seq_ctrl.sv
// AFE frame sequencer: reset, channel readout, sample/hold and TFT integration
// phases. Every AFE pin is decoded from the next state and registered.
module afe_seq_ctrl #(
  parameter int NUM_CH   = 64,
  parameter int T_RST    = 32,
  parameter int T_SH     = 8,
  parameter int T_WAIT   = 8,
  parameter int T_INTW   = 16,
  parameter int CLK_HALF = 4,
  parameter int TW       = 17
) (
  input logic          clk,
  input logic          rst_n,
  afe_seq_ctrl_if.slave bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int OUT_LEN = 2 * NUM_CH * CLK_HALF;
  localparam int MAX_FIX = imax(imax(imax(T_RST, T_SH), imax(T_WAIT, T_INTW)), OUT_LEN);
  localparam int CW      = imax(TW, $clog2(MAX_FIX + 1));
  localparam int PW      = $clog2(CLK_HALF);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RST       = 4'd1;
  localparam logic [3:0] S_RST_WAIT  = 4'd2;
  localparam logic [3:0] S_OUTPUT    = 4'd3;
  localparam logic [3:0] S_SHR       = 4'd4;
  localparam logic [3:0] S_SHR_WAIT  = 4'd5;
  localparam logic [3:0] S_TFT_ON    = 4'd6;
  localparam logic [3:0] S_TFT_OFF   = 4'd7;
  localparam logic [3:0] S_INTG_WAIT = 4'd8;
  localparam logic [3:0] S_SHS       = 4'd9;
  localparam logic [3:0] S_SHS_WAIT  = 4'd10;

  logic [3:0]      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_dwell;
  logic            w_last;
  logic [TW-1:0]   r_ton, r_toff;
  logic [PW-1:0]   r_ph, w_ph_nxt;
  logic            r_hi, w_hi_nxt;
  logic [CH_W-1:0] r_ch, w_ch_nxt;
  logic            w_latch, w_frame_end;
  logic [15:0]     r_frame;
  logic            r_irst, r_shr, r_intg, r_shs, r_aclk, r_entri;
  logic            r_busy, r_done, r_strb, r_dfsm;
  logic [2:0]      r_pga;

  // Dwell length of the current state; TFT times come from the values latched at frame start.
  always_comb begin
    w_dwell = CW'(1);
    case (r_state)
      S_RST:       w_dwell = CW'(T_RST);
      S_RST_WAIT:  w_dwell = CW'(T_WAIT);
      S_OUTPUT:    w_dwell = CW'(OUT_LEN);
      S_SHR:       w_dwell = CW'(T_SH);
      S_SHR_WAIT:  w_dwell = CW'(T_WAIT);
      S_TFT_ON:    w_dwell = CW'(r_ton);
      S_TFT_OFF:   w_dwell = CW'(r_toff);
      S_INTG_WAIT: w_dwell = CW'(T_INTW);
      S_SHS:       w_dwell = CW'(T_SH);
      S_SHS_WAIT:  w_dwell = CW'(T_WAIT);
      default:     w_dwell = CW'(1);
    endcase
    w_last = (r_cnt == w_dwell - CW'(1));
  end

  // Next-state, dwell counter and AFE_CLK phase/channel tracking; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_ph_nxt    = r_ph;
    w_hi_nxt    = r_hi;
    w_ch_nxt    = r_ch;
    w_latch     = 1'b0;
    w_frame_end = 1'b0;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      // r_done marks the first IDLE cycle after a frame; a start there is dropped.
      if (bus.start && !r_done) begin
        w_state_nxt = S_RST;
        w_latch     = 1'b1;
      end
    end else if (w_last) begin
      w_cnt_nxt = '0;
      case (r_state)
        S_RST:       w_state_nxt = S_RST_WAIT;
        S_RST_WAIT:  w_state_nxt = S_OUTPUT;
        S_OUTPUT:    w_state_nxt = S_SHR;
        S_SHR:       w_state_nxt = S_SHR_WAIT;
        S_SHR_WAIT:  w_state_nxt = S_TFT_ON;
        S_TFT_ON:    w_state_nxt = S_TFT_OFF;
        S_TFT_OFF:   w_state_nxt = S_INTG_WAIT;
        S_INTG_WAIT: w_state_nxt = S_SHS;
        S_SHS:       w_state_nxt = S_SHS_WAIT;
        S_SHS_WAIT: begin
          w_frame_end = 1'b1;
          w_state_nxt = bus.cont_mode ? S_RST : S_IDLE;
          w_latch     = bus.cont_mode;
        end
        default:     w_state_nxt = S_IDLE;
      endcase
    end else if (r_state == S_OUTPUT) begin
      if (r_ph == PW'(CLK_HALF - 1)) begin
        w_ph_nxt = '0;
        w_hi_nxt = ~r_hi;
        if (r_hi) w_ch_nxt = r_ch + CH_W'(1);
      end else begin
        w_ph_nxt = r_ph + PW'(1);
      end
    end
    // Phase and channel are held at zero outside readout, so OUTPUT always starts low at channel 0.
    if (w_state_nxt != S_OUTPUT) begin
      w_ph_nxt = '0;
      w_hi_nxt = 1'b0;
      w_ch_nxt = '0;
    end
  end

  // State, dwell counter and readout position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ph    <= '0;
      r_hi    <= 1'b0;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ph    <= w_ph_nxt;
      r_hi    <= w_hi_nxt;
      r_ch    <= w_ch_nxt;
    end
  end

  // TFT times captured at each frame start (zero promoted to one) and the completed-frame count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ton   <= TW'(1);
      r_toff  <= TW'(1);
      r_frame <= '0;
    end else begin
      if (w_latch) begin
        r_ton  <= (bus.tft_on_cyc  == '0) ? TW'(1) : bus.tft_on_cyc;
        r_toff <= (bus.tft_off_cyc == '0) ? TW'(1) : bus.tft_off_cyc;
      end
      if (w_frame_end) r_frame <= r_frame + 16'd1;
    end
  end

  // AFE pins and status flags decoded from the next state so each output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irst  <= 1'b0;
      r_shr   <= 1'b0;
      r_intg  <= 1'b0;
      r_shs   <= 1'b0;
      r_aclk  <= 1'b0;
      r_strb  <= 1'b0;
      r_entri <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pga   <= 3'b111;
      r_dfsm  <= 1'b1;
    end else begin
      r_irst  <= (w_state_nxt == S_RST);
      r_shr   <= (w_state_nxt == S_SHR);
      r_intg  <= (w_state_nxt == S_TFT_ON) || (w_state_nxt == S_TFT_OFF);
      r_shs   <= (w_state_nxt == S_SHS);
      r_aclk  <= (w_state_nxt == S_OUTPUT) && w_hi_nxt;
      r_strb  <= (w_state_nxt == S_OUTPUT) && w_hi_nxt && (w_ph_nxt == PW'(CLK_HALF - 1));
      r_entri <= (w_state_nxt != S_OUTPUT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_frame_end;
      r_pga   <= bus.pga_sel;
      r_dfsm  <= bus.df_sm_in;
    end
  end

  assign bus.AFE_IRST  = r_irst;
  assign bus.AFE_SHR   = r_shr;
  assign bus.AFE_INTG  = r_intg;
  assign bus.AFE_SHS   = r_shs;
  assign bus.AFE_CLK   = r_aclk;
  assign bus.AFE_ENTRI = r_entri;
  assign bus.AFE_DF_SM = r_dfsm;
  assign bus.AFE_PGA   = r_pga;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ch_strobe = r_strb;
  assign bus.ch_idx    = r_ch;
  assign bus.frame_cnt = r_frame;

endmodule
